// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage PC sequencer with MIPS delay-slot redirects.
//   Owns the PC, a single-outstanding imem req/ack handshake and a 1-entry output buffer.
//   Optional feature macro: FETCH_EXC_EN (adds exc_valid flush port and EXC_VECTOR).
// Ports:
//   clk, reset                     clock, async active-high reset
//   redirect_valid/redirect_addr   resolved branch/jump target from D (1-cycle pulse)
//   imem_req/imem_addr             fetch request, held with a stable address until imem_ack
//   imem_ack/imem_rdata            instruction response, 1-cycle pulse
//   if_valid/if_pc/if_instr        output buffer towards D
//   if_ready                       D consumes the buffer when if_valid & if_ready
//   exc_valid                      exception flush (FETCH_EXC_EN only)
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef FETCH_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
`ifdef FETCH_EXC_EN
  input  logic        exc_valid,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d, addr_q, addr_d;
  logic [31:0] if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic        pend_q, pend_d, if_valid_q, if_valid_d;
  logic        exc, drop, issue, ack;
`ifdef FETCH_EXC_EN
  logic        drop_q, drop_d;
  assign exc    = exc_valid;
  assign drop   = drop_q;
  // an exception in WAIT without the ack leaves one response in flight that must be discarded
  assign drop_d = exc_valid ? state_q == S_WAIT && !imem_ack : drop_q && !ack;
`else
  assign exc  = 1'b0;
  assign drop = 1'b0;
`endif
  // issue only into a free buffer slot; the slot frees the same cycle D consumes it
  assign issue     = state_q == S_IDLE && (!if_valid_q || if_ready) && !exc && !reset;
  assign ack       = state_q == S_WAIT && imem_ack;
  assign imem_req  = state_q == S_WAIT || issue;
  // redirect target bypasses pc_q only on the issue cycle; WAIT holds the latched address
  assign imem_addr = state_q == S_WAIT ? addr_q : issue ? (redirect_valid ? redirect_addr : pc_q) : '0;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    if_valid_d = if_valid_q && !if_ready;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
`ifdef FETCH_EXC_EN
    if (exc_valid) begin
      if_valid_d = 1'b0;
      pend_d     = 1'b0;
      pc_d       = EXC_VECTOR;
      state_d    = drop_d ? S_WAIT : S_IDLE;
    end else
`endif
    if (issue) begin
      state_d = S_WAIT;
      addr_d  = imem_addr;
      if (redirect_valid) pc_d = redirect_addr + 32'd4;
    end else if (state_q == S_IDLE) begin
      if (redirect_valid) pc_d = redirect_addr;
    end else if (ack) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      if (!drop) begin
        if_valid_d = 1'b1;
        if_pc_d    = addr_q;
        if_instr_d = imem_rdata;
        pc_d       = redirect_valid ? redirect_addr : pend_q ? tgt_q : addr_q + 32'd4;
      end
    end else if (redirect_valid && !drop) begin
      // delay slot still in flight: remember the newest target until its ack
      pend_d = 1'b1;
      tgt_d  = redirect_addr;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
`ifdef FETCH_EXC_EN
      drop_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
`ifdef FETCH_EXC_EN
      drop_q     <= drop_d;
`endif
    end
  end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: scoreboard bench for fetch_pc_ctrl (request order and delivered instructions).
module tb_fetch_pc_ctrl;
  logic        clk = 0, reset = 1, redirect_valid = 0, imem_ack = 0, if_ready = 1;
  logic [31:0] redirect_addr = 0, imem_rdata = 0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;
`ifdef FETCH_EXC_EN
  logic        exc_valid = 0;
`endif
  int          n_chk = 0, n_fail = 0, lat = 1, cnt = 0;
  int          flush_n = 0, flush_seen = 0, stray_n = 0, stray_seen = 0;
  bit          outst = 0;
  logic [31:0] raddr = 0, e;
  logic [31:0] req_q[$], out_q[$];

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
`ifdef FETCH_EXC_EN
    .exc_valid(exc_valid),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input logic [31:0] a);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_req: no request to %h within 40 cycles", a);
  endtask

  task automatic check_reset_state;
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
  endtask

  // monitor (negedge) + imem responder (posedge+1): instruction word is ~address
  initial forever begin
    @(negedge clk);
    if (flush_n != flush_seen) begin
      outst = 0;
      flush_seen = flush_n;
    end
    if (imem_req && !outst) begin
      outst = 1;
      cnt = lat;
      raddr = imem_addr;
      if (req_q.size() == 0) check("req_unexpected", imem_addr, 32'hFFFF_FFFF);
      else begin
        e = req_q.pop_front();
        check("req_addr", imem_addr, e);
      end
    end else if (imem_ack) outst = 0;
    if (if_valid && if_ready) begin
      if (out_q.size() == 0) check("out_unexpected", if_pc, 32'hFFFF_FFFF);
      else begin
        e = out_q.pop_front();
        check("if_pc", if_pc, e);
        check("if_instr", if_instr, ~e);
      end
    end
    @(posedge clk);
    #1;
    imem_ack = 0;
    if (stray_n != stray_seen) begin
      stray_seen = stray_n;
      imem_ack = 1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (outst) begin
      if (cnt <= 1) begin
        imem_ack = 1;
        imem_rdata = ~raddr;
      end else cnt--;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FETCH_EXC_EN
    req_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3100, 32'h3104, 32'h3200, 32'h3204,
              32'h3208, 32'h320C, 32'h3210, 32'h3000, 32'h3004, 32'h4180};
`else
    req_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3100, 32'h3104, 32'h3200, 32'h3204,
              32'h3208, 32'h320C, 32'h3210, 32'h3000, 32'h3004};
`endif
    out_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3100, 32'h3104, 32'h3200, 32'h3204,
              32'h3208, 32'h320C, 32'h3000};
    @(negedge clk);
    check_reset_state();
    // sequential fetch from RESET_PC
    step;
    reset = 0;
    @(negedge clk);
    check("first_if_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    check("wait_if_valid", {31'd0, if_valid}, 32'd0);
    // branch resolved while delay slot 300C is still outstanding
    wait_req(32'h3008);
    step;
    lat = 2;
    wait_req(32'h300C);
    step;
    redirect_valid = 1;
    redirect_addr = 32'h3100;
    step;
    redirect_valid = 0;
    lat = 1;
    // redirect coinciding with the delay-slot ack
    wait_req(32'h3104);
    step;
    redirect_valid = 1;
    redirect_addr = 32'h3200;
    step;
    redirect_valid = 0;
    // D stalls with the buffer full
    wait_req(32'h3208);
    step;
    if_ready = 0;
    step;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_imem_req", {31'd0, imem_req}, 32'd0);
      check("stall_if_pc", if_pc, 32'h3208);
      check("stall_if_instr", if_instr, ~32'h3208);
    end
    step;
    if_ready = 1;
    // reset while a request is outstanding, stray ack right after release
    wait_req(32'h320C);
    step;
    lat = 5;
    wait_req(32'h3210);
    step;
    reset = 1;
    flush_n++;
    lat = 1;
    @(negedge clk);
    check_reset_state();
    step;
    stray_n++;
    step;
    reset = 0;
`ifdef FETCH_EXC_EN
    // exception while 3004 is in flight: its ack is dropped, fetch resumes at EXC_VECTOR
    wait_req(32'h3000);
    step;
    lat = 3;
    wait_req(32'h3004);
    step;
    exc_valid = 1;
    step;
    exc_valid = 0;
    lat = 1;
    @(negedge clk);
    check("exc_if_valid", {31'd0, if_valid}, 32'd0);
    wait_req(32'h4180);
`else
    wait_req(32'h3004);
`endif
    step;
    if_ready = 0;
    repeat (4) step;
    @(negedge clk);
    check("end_imem_req", {31'd0, imem_req}, 32'd0);
    check("end_if_valid", {31'd0, if_valid}, 32'd1);
    check("req_q_left", req_q.size(), 32'd0);
    check("out_q_left", out_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
